// File: rtl/preamble_pkg.sv
// Shared tables, state encoding and bin helpers for the legacy-preamble
// frequency-domain sequencer.
package preamble_pkg;

    localparam int unsigned NBINS = 64;
    localparam int unsigned BIN_W = 6;

    // 2-bit sign codes stored per natural bin
    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] CP = 2'b01;
    localparam logic [1:0] CM = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STF  = 2'd1,
        LTF  = 2'd2,
        DONE = 2'd3
    } state_e;

    // S(k) by natural bin n; bins 32..63 carry negative k = n-64
    localparam logic [1:0] STF_TAB [NBINS] = '{
        C0, C0, C0, C0, CM, C0, C0, C0,
        CM, C0, C0, C0, CP, C0, C0, C0,
        CP, C0, C0, C0, CP, C0, C0, C0,
        CP, C0, C0, C0, C0, C0, C0, C0,
        C0, C0, C0, C0, C0, C0, C0, C0,
        CP, C0, C0, C0, CM, C0, C0, C0,
        CP, C0, C0, C0, CM, C0, C0, C0,
        CM, C0, C0, C0, CP, C0, C0, C0
    };

    // L(k) by natural bin n; DC and |k|>26 are zero
    localparam logic [1:0] LTF_TAB [NBINS] = '{
        C0, CP, CM, CM, CP, CP, CM, CP,
        CM, CP, CM, CM, CM, CM, CM, CP,
        CP, CM, CM, CP, CM, CP, CM, CP,
        CP, CP, CP, C0, C0, C0, C0, C0,
        C0, C0, C0, C0, C0, C0, CP, CP,
        CM, CM, CP, CP, CM, CP, CM, CP,
        CP, CP, CP, CP, CP, CM, CM, CP,
        CP, CM, CP, CM, CP, CP, CP, CP
    };

    // Natural-order bin to signed subcarrier index: n-64 for n>=32
    function automatic logic signed [BIN_W:0] bin_to_subcar(input logic [BIN_W-1:0] n);
        return $signed({n[BIN_W-1], n});
    endfunction

endpackage

// File: rtl/preamble_seq_rom.sv
// Combinational sign-code lookup for STF/LTF by natural bin index.
module preamble_seq_rom
    import preamble_pkg::*;
(
    input  logic [BIN_W-1:0] n_i,
    input  logic             is_ltf_i,
    output logic [1:0]       code_c_o
);

    assign code_c_o = is_ltf_i ? LTF_TAB[n_i] : STF_TAB[n_i];

endmodule

// File: rtl/preamble_freq_seq.sv
// Streams L-STF then L-LTF subcarrier values into the IFFT, one bin per
// accepted beat, with registered valid/ready output and per-symbol last.
module preamble_freq_seq
    import preamble_pkg::*;
#(
    parameter int unsigned   W       = 16,
    parameter logic [W-1:0]  AMP_LTF = W'(16'h4000),
    parameter logic [W-1:0]  AMP_STF = W'(16'h5E00),
    parameter int unsigned   N_STF   = 1,
    parameter int unsigned   N_LTF   = 2,
    parameter int unsigned   ROT     = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           neg_ltf2,
    output logic [2*W-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last,
    output logic           m_is_ltf,
    output logic           busy,
    output logic           done
);

    localparam logic [2:0]       STF_LAST = 3'(N_STF - 1);
    localparam logic [2:0]       LTF_LAST = 3'(N_LTF - 1);
    localparam logic [BIN_W-1:0] ROT_B    = BIN_W'(ROT);

    state_e           state_q, state_d;
    logic [BIN_W-1:0] b_q, b_d;
    logic [2:0]       s_q, s_d;
    logic             neg_q, neg_d;

    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ltf_q, ltf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*W-1:0]   data_q, data_d;

    logic             accept;
    logic [BIN_W-1:0] n_d;
    logic [1:0]       code;
    logic [W-1:0]     mag, ival;
    logic             flip;

    assign accept = valid_q && m_ready;

    // Next-state: counters advance only on accepted beats; abort wins
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        s_d     = s_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (N_STF != 0) ? STF : LTF;
                    b_d     = '0;
                    s_d     = '0;
                    neg_d   = neg_ltf2;
                end
            end
            STF: begin
                if (accept) begin
                    b_d = b_q + BIN_W'(1);
                    if (b_q == BIN_W'(NBINS - 1)) begin
                        if (s_q == STF_LAST) begin
                            state_d = LTF;
                            s_d     = '0;
                        end else begin
                            s_d = s_q + 3'd1;
                        end
                    end
                end
            end
            LTF: begin
                if (accept) begin
                    b_d = b_q + BIN_W'(1);
                    if (b_q == BIN_W'(NBINS - 1)) begin
                        if (s_q == LTF_LAST) begin
                            state_d = DONE;
                        end else begin
                            s_d = s_q + 3'd1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Output words are computed from next-state so they register with it
    assign ltf_d = (state_d == LTF);
    assign n_d   = b_d + ROT_B;

    preamble_seq_rom u_rom (
        .n_i      (n_d),
        .is_ltf_i (ltf_d),
        .code_c_o (code)
    );

    always_comb begin
        valid_d = (state_d == STF) || (state_d == LTF);
        last_d  = valid_d && (b_d == BIN_W'(NBINS - 1));
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        mag     = ltf_d ? AMP_LTF : AMP_STF;
        flip    = ltf_d && neg_d && s_d[0];
        ival    = '0;
        case (code)
            CP:      ival = flip ? (~mag + W'(1)) : mag;
            CM:      ival = flip ? mag : (~mag + W'(1));
            default: ival = '0;
        endcase
        if (!valid_d) begin
            ival = '0;
        end
        data_d = ltf_d ? {ival, W'(0)} : {ival, ival};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            s_q     <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ltf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            s_q     <= s_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ltf_q   <= ltf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign m_is_ltf = ltf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_preamble_freq_seq.sv
// Directed bench for preamble_freq_seq: default and rotated instances,
// backpressure, LTF negation, abort and asynchronous reset.
module tb_preamble_freq_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic neg_ltf2 = 1'b0;
    logic m_ready = 1'b0;
    logic sel = 1'b0;

    logic [31:0] d_data, r_data;
    logic d_valid, d_last, d_ltf, d_busy, d_done;
    logic r_valid, r_last, r_ltf, r_busy, r_done;

    always #5 clk = ~clk;

    preamble_freq_seq dut (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
        .neg_ltf2(neg_ltf2), .m_data(d_data), .m_valid(d_valid), .m_ready(m_ready),
        .m_last(d_last), .m_is_ltf(d_ltf), .busy(d_busy), .done(d_done)
    );

    preamble_freq_seq #(.ROT(6), .N_STF(0), .N_LTF(1)) dut_r (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
        .neg_ltf2(neg_ltf2), .m_data(r_data), .m_valid(r_valid), .m_ready(m_ready),
        .m_last(r_last), .m_is_ltf(r_ltf), .busy(r_busy), .done(r_done)
    );

    logic [31:0] o_data;
    logic o_valid, o_last, o_ltf, o_busy, o_done;
    assign o_data  = sel ? r_data  : d_data;
    assign o_valid = sel ? r_valid : d_valid;
    assign o_last  = sel ? r_last  : d_last;
    assign o_ltf   = sel ? r_ltf   : d_ltf;
    assign o_busy  = sel ? r_busy  : d_busy;
    assign o_done  = sel ? r_done  : d_done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] cap [0:255];
    logic        cap_last [0:255];
    logic        cap_ltf [0:255];
    int nb, done_at, last_acc, stall_err, bad_idx, errs;

    // 802.11a L(k) for k = -26..26
    int ltf_l [0:52] = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                         0,
                         1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1, -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};

    function automatic int stf_s(input int k);
        case (k)
            -24, -16, -4, 12, 16, 20, 24: return 1;
            -20, -12, -8, 4, 8:           return -1;
            default:                      return 0;
        endcase
    endfunction

    function automatic logic [31:0] model(input int b, input int s, input bit ltf, input bit neg, input int rot);
        int n, k, v;
        logic [15:0] iv;
        n = (b + rot) % 64;
        k = (n < 32) ? n : n - 64;
        if (ltf) begin
            v = (k >= -26 && k <= 26) ? ltf_l[k + 26] : 0;
            if (neg && (s % 2 == 1)) v = -v;
            iv = 16'(v * 16384);
            return {iv, 16'h0000};
        end
        v  = stf_s(k);
        iv = 16'(v * 24064);
        return {iv, iv};
    endfunction

    // Number of captured beats disagreeing with the model; first one in bad_idx
    function automatic int seq_errs(input int nstf, input bit neg, input int rot);
        int e, sym, b, s;
        bit ltf;
        e = 0;
        bad_idx = -1;
        for (int i = 0; i < nb; i++) begin
            sym = i / 64;
            b   = i % 64;
            ltf = (sym >= nstf);
            s   = ltf ? sym - nstf : sym;
            if (cap[i] !== model(b, s, ltf, neg, rot) || cap_last[i] !== (b == 63) || cap_ltf[i] !== ltf) begin
                if (bad_idx < 0) bad_idx = i;
                e++;
            end
        end
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from a negedge, capturing accepted beats until done or budget
    task automatic collect(input int low_pct, input int budget, input int restart_at);
        logic        stall;
        logic [31:0] pd;
        logic        pl, pt;
        nb = 0; done_at = -1; last_acc = -1; stall_err = 0;
        stall = 1'b0; pd = '0; pl = 1'b0; pt = 1'b0;
        for (int c = 0; c < budget; c++) begin
            m_ready = (low_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= low_pct);
            if (o_done) begin
                done_at = c;
                break;
            end
            start = (c == restart_at);
            if (stall && (!o_valid || o_data !== pd || o_last !== pl || o_ltf !== pt)) stall_err++;
            if (o_valid && m_ready && nb < 256) begin
                cap[nb] = o_data; cap_last[nb] = o_last; cap_ltf[nb] = o_ltf;
                nb++;
                last_acc = c;
            end
            stall = o_valid && !m_ready;
            pd = o_data; pl = o_last; pt = o_ltf;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({d_valid, d_last, d_ltf, d_busy, d_done, d_data} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_default: outputs %h, want 0", {d_valid, d_last, d_ltf, d_busy, d_done, d_data});
        end
        vectors++;
        if ({r_valid, r_last, r_ltf, r_busy, r_done, r_data} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_rot: outputs %h, want 0", {r_valid, r_last, r_ltf, r_busy, r_done, r_data});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default();
        sel = 1'b0; neg_ltf2 = 1'b0; m_ready = 1'b1;
        pulse_start();
        vectors++;
        if ({o_valid, o_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL first_beat_latency: valid/busy %b, want 11", {o_valid, o_busy});
        end
        collect(0, 400, -1);
        vectors++;
        if (nb !== 192) begin miscompares++; $display("FAIL default_count: %0d beats, want 192", nb); end
        errs = seq_errs(1, 1'b0, 0);
        vectors++;
        if (errs !== 0) begin miscompares++; $display("FAIL default_seq: %0d bad beats (first %0d), want 0", errs, bad_idx); end
        vectors++;
        if (cap[4] !== 32'hA200A200) begin miscompares++; $display("FAIL stf_k4: got %h want A200A200", cap[4]); end
        vectors++;
        if (cap[65] !== 32'h40000000) begin miscompares++; $display("FAIL ltf_k1: got %h want 40000000", cap[65]); end
        vectors++;
        if ({cap[0], cap[32], cap[64], cap[96]} !== 128'd0) begin
            miscompares++;
            $display("FAIL zero_bins: got %h %h %h %h want 0", cap[0], cap[32], cap[64], cap[96]);
        end
        vectors++;
        if ({cap_last[62], cap_last[63], cap_last[127], cap_last[191]} !== 4'b0111) begin
            miscompares++;
            $display("FAIL last_positions: got %b want 0111", {cap_last[62], cap_last[63], cap_last[127], cap_last[191]});
        end
        vectors++;
        if (done_at < 0 || done_at !== last_acc + 1) begin
            miscompares++;
            $display("FAIL done_timing: done at %0d, want %0d", done_at, last_acc + 1);
        end
        // start while DONE must not launch a new preamble
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_valid, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL start_in_done: valid/busy/done %b, want 000", {o_valid, o_busy, o_done});
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0; neg_ltf2 = 1'b0;
        pulse_start();
        collect(30, 2000, -1);
        vectors++;
        if (nb !== 192) begin miscompares++; $display("FAIL bp_count: %0d beats, want 192", nb); end
        errs = seq_errs(1, 1'b0, 0);
        vectors++;
        if (errs !== 0) begin miscompares++; $display("FAIL bp_seq: %0d bad beats (first %0d), want 0", errs, bad_idx); end
        vectors++;
        if (stall_err !== 0) begin miscompares++; $display("FAIL bp_stable: %0d unstable stalls, want 0", stall_err); end
        vectors++;
        if (done_at < 0 || done_at !== last_acc + 1) begin
            miscompares++;
            $display("FAIL bp_done: done at %0d, want %0d", done_at, last_acc + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_rot();
        sel = 1'b1; neg_ltf2 = 1'b0; m_ready = 1'b1;
        pulse_start();
        collect(0, 200, -1);
        vectors++;
        if (nb !== 64) begin miscompares++; $display("FAIL rot_count: %0d beats, want 64", nb); end
        // bin 6 carries L(6) = -1 in the standard long training sequence
        vectors++;
        if (cap[0] !== 32'hC0000000) begin miscompares++; $display("FAIL rot_first: got %h want C0000000", cap[0]); end
        vectors++;
        if (cap[58] !== 32'h00000000) begin miscompares++; $display("FAIL rot_wrap: got %h want 0", cap[58]); end
        errs = seq_errs(0, 1'b0, 6);
        vectors++;
        if (errs !== 0) begin miscompares++; $display("FAIL rot_seq: %0d bad beats (first %0d), want 0", errs, bad_idx); end
        vectors++;
        if (done_at < 0 || done_at !== last_acc + 1) begin
            miscompares++;
            $display("FAIL rot_done: done at %0d, want %0d", done_at, last_acc + 1);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_neg();
        logic [15:0] a;
        int ne;
        sel = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        neg_ltf2 = 1'b1; start = 1'b1;
        @(negedge clk);
        neg_ltf2 = 1'b0; start = 1'b0;
        collect(0, 400, -1);
        vectors++;
        if (nb !== 192) begin miscompares++; $display("FAIL neg_count: %0d beats, want 192", nb); end
        errs = seq_errs(1, 1'b1, 0);
        vectors++;
        if (errs !== 0) begin miscompares++; $display("FAIL neg_seq: %0d bad beats (first %0d), want 0", errs, bad_idx); end
        ne = 0;
        for (int i = 0; i < 64; i++) begin
            a = cap[64 + i][31:16];
            a = -a;
            if (cap[128 + i] !== {a, 16'h0000}) ne++;
        end
        vectors++;
        if (ne !== 0) begin miscompares++; $display("FAIL neg_mirror: %0d bins not negated, want 0", ne); end
        vectors++;
        if ({cap[65], cap[129]} !== {32'h40000000, 32'hC0000000}) begin
            miscompares++;
            $display("FAIL neg_k1: got %h %h want 40000000 C0000000", cap[65], cap[129]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int nacc, dseen;
        sel = 1'b0; neg_ltf2 = 1'b0; m_ready = 1'b1;
        pulse_start();
        nacc = 0;
        for (int c = 0; c < 300; c++) begin
            if (nacc == 100) break;
            if (o_valid) nacc++;
            @(negedge clk);
        end
        vectors++;
        if ({o_valid, o_data} !== {1'b1, model(36, 0, 1'b1, 1'b0, 0)}) begin
            miscompares++;
            $display("FAIL abort_beat100: got %b/%h want 1/%h", o_valid, o_data, model(36, 0, 1'b1, 1'b0, 0));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({o_valid, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_idle: valid/busy/done %b, want 000", {o_valid, o_busy, o_done});
        end
        dseen = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done || o_valid) dseen++;
            @(negedge clk);
        end
        vectors++;
        if (dseen !== 0) begin miscompares++; $display("FAIL abort_quiet: %0d active cycles, want 0", dseen); end
        pulse_start();
        collect(0, 400, -1);
        errs = seq_errs(1, 1'b0, 0);
        vectors++;
        if (nb !== 192 || errs !== 0) begin
            miscompares++;
            $display("FAIL abort_restart: %0d beats %0d bad, want 192 0", nb, errs);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        sel = 1'b0; neg_ltf2 = 1'b0; m_ready = 1'b1;
        pulse_start();
        collect(0, 80, -1);
        vectors++;
        if ({o_valid, o_ltf} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_pre: valid/ltf %b, want 11", {o_valid, o_ltf});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({d_valid, d_last, d_ltf, d_busy, d_done, d_data} !== 37'd0) begin
            miscompares++;
            $display("FAIL rst_async: outputs %h, want 0", {d_valid, d_last, d_ltf, d_busy, d_done, d_data});
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        collect(0, 400, 30);
        errs = seq_errs(1, 1'b0, 0);
        vectors++;
        if (nb !== 192 || errs !== 0) begin
            miscompares++;
            $display("FAIL start_while_busy: %0d beats %0d bad, want 192 0", nb, errs);
        end
        vectors++;
        if (done_at < 0 || done_at !== last_acc + 1) begin
            miscompares++;
            $display("FAIL busy_done: done at %0d, want %0d", done_at, last_acc + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_default();
        test_backpressure();
        test_rot();
        test_neg();
        test_abort();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
